square_duty_ctrl: RTL and testbench
===================================

// Module: square_duty_ctrl
// PURPOSE
//  Controller sequencing the square/pulse generator's duty configuration from user keys.
//  Turns mode/up/down key inputs into duty_mode / duty_cont / cont_enable.
//  Press-and-hold on up/down auto-repeats.
//  New settings are staged in shadow registers and committed only at a phase wrap, so no partial-period pulses occur.
//  Sits between the debounced key block and the square generator.
// PARAMETERS
//  HOLD_CYCLES     50_000_000  cycles a key must stay held before auto-repeat starts (>=2)
//  REPEAT_CYCLES   5_000_000   cycles between auto-repeat steps (>=1)
//  COMMIT_TIMEOUT  100_000_000 cycles without a phase wrap before a forced commit (>=1)
//  CONT_RESET      7'd50       duty_cont value after reset (1..99)
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  phase        in   12  phase word of the generator's phase accumulator
//  key_mode     in   1   debounced level: mode select
//  key_up       in   1   debounced level: increase continuous duty
//  key_down     in   1   debounced level: decrease continuous duty
//  duty_mode    out  2   committed fixed duty: 00=1/2 01=1/3 10=1/4 11=1/7
//  duty_cont    out  7   committed continuous duty percentage, 1..99
//  cont_enable  out  1   committed continuous-mode enable
//  pending      out  1   shadow settings differ from committed settings
// BEHAVIOUR
//  Reset (async, all flops): duty_mode=00, duty_cont=CONT_RESET, cont_enable=0, pending=0.
//   Shadow registers take the same values. FSM=IDLE. Key and phase history registers = 0.
//  Key edges: each key registered once. Rising edge = key high && key_q low.
//   A key held through reset release produces no edge.
//  Mode cycle (key_mode rising edge, one step per edge):
//   1/2 -> 1/3 -> 1/4 -> 1/7 -> CONT -> 1/2.
//   Entering CONT: sh_cen=1, sh_mode is kept. Leaving CONT: sh_cen=0, sh_mode=00. sh_cont is never altered by mode changes.
//  Step FSM (active only while sh_cen=1; otherwise held in IDLE and up/down are ignored):
//   IDLE  : exactly one of up/down rises -> apply step, load hold counter, go HOLD.
//   HOLD  : key released -> IDLE.
//           Counter reaches HOLD_CYCLES-1 -> apply step, go REPEAT.
//   REPEAT: a step every REPEAT_CYCLES cycles while held. Release -> IDLE.
//   Direction is latched on leaving IDLE. Both keys high in any state -> IDLE, no step.
//   Mode edge in the same cycle: mode change wins, FSM -> IDLE, no step that cycle.
//   A step moves sh_cont by +/-1, saturating at 99 and at 1. A saturated step is silent, not an error.
//  Shadow update latency: key edge in cycle t -> shadow changes at the clock edge ending cycle t+1.
//  Wrap detection: phase_q = phase delayed by one cycle. wrap = (phase < phase_q), strictly less.
//   Equal consecutive values are not a wrap.
//  Commit: in a wrap cycle, or when the timeout counter reaches COMMIT_TIMEOUT-1, all three outputs load the shadows in that cycle.
//   The timeout counter clears on every wrap and every commit. This covers a stalled or zero-frequency phase.
//   All three outputs always update together, never partially.
//   Shadow update and commit in the same cycle: the commit takes the pre-update shadow. The new value waits for the next commit.
//  pending = registered (shadow != committed). It is valid one cycle after either side changes.
//  Reset mid-hold or mid-repeat: everything returns to reset values immediately. No step is issued on release.
// STRUCTURE
//  Package square_ctrl_pkg:
//   DUTY_HALF/THIRD/QUARTER/SEVENTH 2-bit codes
//   DUTY_CONT_MIN=1, DUTY_CONT_MAX=99
//   step-FSM state encoding {IDLE, HOLD, REPEAT}
//  Sub-module key_autorepeat: the step FSM plus hold/repeat counters.
//   Inputs: up, down, enable. Outputs: step_pulse, step_dir.
//  Top level keeps the mode cycle, shadows, saturation, wrap detect, timeout and commit.
// TESTING  (bench uses HOLD_CYCLES=16, REPEAT_CYCLES=4, COMMIT_TIMEOUT=64; phase ramps +64/cycle, wrap every 64 cycles)
//  1 Reset: all outputs at reset values, pending=0.
//    Pulse key_mode 5x, waiting 70 cycles each.
//    -> committed sequence 01, 10, 11, CONT(cen=1, mode 11), then back to 00 with cen=0.
//  2 In CONT at 50: tap key_up for 3 cycles.
//    -> sh_cont=51 and pending=1 two cycles later. Outputs stay at 50 until the next wrap.
//    -> duty_cont=51 in the wrap cycle; pending=0 one cycle later.
//  3 Hold key_up for 40 cycles from 50 -> exactly 1 + 1 + 5 = 7 steps (sh_cont=57).
//    Steps land 1 cycle after the edge, at hold end, then every 4 cycles.
//  4 Saturation: at 98, hold key_up 60 cycles -> sh_cont stops at 99.
//    Down from 2, held -> stops at 1. Never 0 or 100.
//  5 Both keys high together, and key_up edge coincident with key_mode edge.
//    -> no step. In the coincident case mode advances to 1/2 with cen=0.
//  6 Phase frozen at 700: change mode -> commit after exactly 64 cycles via timeout.
//    Async reset asserted mid-REPEAT -> outputs at reset values with no clock edge required.

Source files
------------

// File: rtl/square_ctrl_pkg.sv
// Shared codes, limits, step-FSM encoding and the saturating step helper
// for the square generator duty controller.
package square_ctrl_pkg;

  localparam logic [1:0] DUTY_HALF    = 2'b00;
  localparam logic [1:0] DUTY_THIRD   = 2'b01;
  localparam logic [1:0] DUTY_QUARTER = 2'b10;
  localparam logic [1:0] DUTY_SEVENTH = 2'b11;

  localparam logic [6:0] DUTY_CONT_MIN = 7'd1;
  localparam logic [6:0] DUTY_CONT_MAX = 7'd99;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } step_state_e;

  // A step at either limit leaves the value where it is.
  function automatic logic [6:0] sat_step(input logic [6:0] v, input logic up);
    if (up) return (v >= DUTY_CONT_MAX) ? DUTY_CONT_MAX : v + 7'd1;
    else    return (v <= DUTY_CONT_MIN) ? DUTY_CONT_MIN : v - 7'd1;
  endfunction

endpackage

// File: rtl/square_duty_ctrl_if.sv
// Key/phase inputs and committed duty outputs between the key block,
// the duty controller and the square generator.
interface square_duty_ctrl_if;
  logic [11:0] phase;
  logic        key_mode;
  logic        key_up;
  logic        key_down;
  logic [1:0]  duty_mode;
  logic [6:0]  duty_cont;
  logic        cont_enable;
  logic        pending;

  modport master (
    output phase, key_mode, key_up, key_down,
    input  duty_mode, duty_cont, cont_enable, pending
  );

  modport slave (
    input  phase, key_mode, key_up, key_down,
    output duty_mode, duty_cont, cont_enable, pending
  );
endinterface

// File: rtl/square_duty_ctrl_key_autorepeat.sv
// Up/down step generator with press-and-hold auto-repeat.
// state  | meaning
// IDLE   | waiting for a single up or down rising edge
// HOLD   | key held, counting down to the first repeat
// REPEAT | key still held, one step per repeat period
module key_autorepeat
  import square_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic up_i,
  input  logic down_i,
  input  logic enable_i,
  output logic step_pulse_o,
  output logic step_dir_o
);

  localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LOAD = CW'(REPEAT_CYCLES - 1);

  step_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic          up_q, down_q, dir_q, step_q;
  logic          up_rise, down_rise, both, held;

  assign up_rise   = up_i & ~up_q;
  assign down_rise = down_i & ~down_q;
  assign both      = up_i & down_i;
  assign held      = dir_q ? up_i : down_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      up_q   <= up_i;
      down_q <= down_i;
      step_q <= 1'b0;
      if (!enable_i || both) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (up_rise || down_rise) begin
              state_q <= HOLD;
              dir_q   <= up_rise;
              cnt_q   <= HOLD_LOAD;
              step_q  <= 1'b1;
            end
          end
          HOLD, REPEAT: begin
            if (!held) begin
              state_q <= IDLE;
            end else if (cnt_q == '0) begin
              state_q <= REPEAT;
              cnt_q   <= REPEAT_LOAD;
              step_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign step_pulse_o = step_q;
  assign step_dir_o   = dir_q;

endmodule

// File: rtl/square_duty_ctrl.sv
// Duty controller: mode cycling, shadow settings, and commit of all outputs
// together at a phase wrap or after a wrap-less timeout.
module square_duty_ctrl
  import square_ctrl_pkg::*;
#(
  parameter int         HOLD_CYCLES    = 50_000_000,
  parameter int         REPEAT_CYCLES  = 5_000_000,
  parameter int         COMMIT_TIMEOUT = 100_000_000,
  parameter logic [6:0] CONT_RESET     = 7'd50
) (
  input logic               clk,
  input logic               rst_n,
  square_duty_ctrl_if.slave bus
);

  localparam int TW = $clog2(COMMIT_TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(COMMIT_TIMEOUT - 1);

  logic          armed_q, mode_key_q, mode_pulse_q;
  logic [11:0]   phase_q;
  logic [TW-1:0] tmo_q;
  logic [1:0]    sh_mode_q, sh_mode_d, mode_q;
  logic [6:0]    sh_cont_q, sh_cont_d, cont_q;
  logic          sh_cen_q, sh_cen_d, cen_q, pending_q;
  logic          mode_rise, step_pulse, step_dir, wrap, commit;

  // armed_q masks the first cycle after reset so a key held through reset is not an edge.
  assign mode_rise = armed_q & bus.key_mode & ~mode_key_q;
  assign wrap      = bus.phase < phase_q;
  assign commit    = wrap | (tmo_q == TMO_LAST);

  key_autorepeat #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_autorepeat (
    .clk         (clk),
    .rst_n       (rst_n),
    .up_i        (bus.key_up),
    .down_i      (bus.key_down),
    .enable_i    (armed_q & sh_cen_q & ~mode_rise),
    .step_pulse_o(step_pulse),
    .step_dir_o  (step_dir)
  );

  always_comb begin
    sh_mode_d = sh_mode_q;
    sh_cont_d = sh_cont_q;
    sh_cen_d  = sh_cen_q;
    if (mode_pulse_q) begin
      if (sh_cen_q) begin
        sh_cen_d  = 1'b0;
        sh_mode_d = DUTY_HALF;
      end else if (sh_mode_q == DUTY_SEVENTH) begin
        sh_cen_d = 1'b1;
      end else begin
        sh_mode_d = sh_mode_q + 2'd1;
      end
    end else if (step_pulse && sh_cen_q) begin
      sh_cont_d = sat_step(sh_cont_q, step_dir);
    end
  end

  // Commit samples the shadows before this cycle's update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q      <= 1'b0;
      mode_key_q   <= 1'b0;
      mode_pulse_q <= 1'b0;
      phase_q      <= '0;
      tmo_q        <= '0;
      sh_mode_q    <= DUTY_HALF;
      sh_cont_q    <= CONT_RESET;
      sh_cen_q     <= 1'b0;
      mode_q       <= DUTY_HALF;
      cont_q       <= CONT_RESET;
      cen_q        <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      armed_q      <= 1'b1;
      mode_key_q   <= bus.key_mode;
      mode_pulse_q <= mode_rise;
      phase_q      <= bus.phase;
      sh_mode_q    <= sh_mode_d;
      sh_cont_q    <= sh_cont_d;
      sh_cen_q     <= sh_cen_d;
      pending_q    <= (sh_mode_q != mode_q) | (sh_cont_q != cont_q) | (sh_cen_q != cen_q);
      if (commit) begin
        mode_q <= sh_mode_q;
        cont_q <= sh_cont_q;
        cen_q  <= sh_cen_q;
        tmo_q  <= '0;
      end else begin
        tmo_q <= tmo_q + TW'(1);
      end
    end
  end

  assign bus.duty_mode   = mode_q;
  assign bus.duty_cont   = cont_q;
  assign bus.cont_enable = cen_q;
  assign bus.pending     = pending_q;

endmodule

// File: tb/tb_square_duty_ctrl.sv
// Scoreboard bench for square_duty_ctrl: a per-cycle reference model pushes
// expected outputs, a negedge monitor pops and compares.
module tb_square_duty_ctrl;

  localparam int HOLD = 16;
  localparam int REP  = 4;
  localparam int TMO  = 64;

  logic clk = 1'b0;
  logic rst_n;

  square_duty_ctrl_if bus ();

  square_duty_ctrl #(
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP),
    .COMMIT_TIMEOUT(TMO),
    .CONT_RESET    (7'd50)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] mode;
    logic [6:0] cont;
    logic       cen;
    logic       pend;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: position 0..3 = fixed duties, 4 = continuous mode.
  int sh_pos, sh_cont, com_pos, com_cont, since, hold_len, ph_prev;
  bit pend, armed, m_prev, u_prev, d_prev, hold_act, hold_dir;
  bit mode_pend, step_pend, dir_pend;

  bit          k_m, k_u, k_d, frozen;
  logic [11:0] ph_val;

  function automatic obs_t expected();
    obs_t o;
    o.mode = (com_pos == 4) ? 2'd3 : 2'(com_pos);
    o.cont = 7'(com_cont);
    o.cen  = (com_pos == 4);
    o.pend = pend;
    return o;
  endfunction

  task automatic model_reset();
    sh_pos = 0; sh_cont = 50; com_pos = 0; com_cont = 50;
    since = 0; hold_len = 0; ph_prev = 0;
    pend = 0; armed = 0; m_prev = 0; u_prev = 0; d_prev = 0;
    hold_act = 0; hold_dir = 0; mode_pend = 0; step_pend = 0; dir_pend = 0;
  endtask

  task automatic model_step(input bit m, input bit u, input bit d, input int ph);
    bit mode_e, up_e, dn_e, en, fire, new_pend, commit;
    mode_e = armed && m && !m_prev;
    up_e   = armed && u && !u_prev;
    dn_e   = armed && d && !d_prev;
    en     = armed && (sh_pos == 4) && !mode_e;
    fire   = 0;
    if (!en || (u && d)) hold_act = 0;
    else if (!hold_act) begin
      if (up_e && !d) begin hold_act = 1; hold_dir = 1; hold_len = 0; fire = 1; end
      else if (dn_e && !u) begin hold_act = 1; hold_dir = 0; hold_len = 0; fire = 1; end
    end else if (!(hold_dir ? u : d)) hold_act = 0;
    else begin
      hold_len++;
      if (hold_len >= HOLD && (hold_len - HOLD) % REP == 0) fire = 1;
    end
    new_pend = (sh_pos != com_pos) || (sh_cont != com_cont);
    commit   = (ph < ph_prev) || (since == TMO - 1);
    if (commit) begin com_pos = sh_pos; com_cont = sh_cont; since = 0; end
    else since++;
    if (mode_pend) sh_pos = (sh_pos + 1) % 5;
    else if (step_pend && sh_pos == 4)
      sh_cont = dir_pend ? ((sh_cont < 99) ? sh_cont + 1 : 99)
                         : ((sh_cont > 1) ? sh_cont - 1 : 1);
    mode_pend = mode_e;
    step_pend = fire;
    dir_pend  = hold_dir;
    pend      = new_pend;
    m_prev = m; u_prev = u; d_prev = d;
    armed   = 1;
    ph_prev = ph;
  endtask

  task automatic apply();
    ph_val       = frozen ? 12'd700 : ph_val + 12'd64;
    bus.key_mode = k_m;
    bus.key_up   = k_u;
    bus.key_down = k_d;
    bus.phase    = ph_val;
    exp_q.push_back(expected());
    model_step(k_m, k_u, k_d, int'(ph_val));
  endtask

  task automatic cyc(input bit m, input bit u, input bit d);
    @(posedge clk);
    #1;
    k_m = m; k_u = u; k_d = d;
    apply();
  endtask

  task automatic run(input int n, input bit m, input bit u, input bit d);
    repeat (n) cyc(m, u, d);
  endtask

  task automatic goto_cont();
    for (int j = 0; j < 5 && sh_pos != 4; j++) begin
      cyc(1, 0, 0);
      run(3, 0, 0, 0);
    end
  endtask

  // Asserts reset without waiting for a clock edge and checks outputs at once.
  task automatic reset_seq(input bit mid);
    obs_t a;
    if (mid) begin @(posedge clk); #2; end
    rst_n = 1'b0;
    #1;
    a = {bus.duty_mode, bus.duty_cont, bus.cont_enable, bus.pending};
    n_cmp++;
    if (a !== {2'd0, 7'd50, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL async_reset: got mode=%0d cont=%0d cen=%0b pend=%0b, expected mode=0 cont=50 cen=0 pend=0",
               a.mode, a.cont, a.cen, a.pend);
    end
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    apply();
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.duty_mode, bus.duty_cont, bus.cont_enable, bus.pending};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs @%0t: got mode=%0d cont=%0d cen=%0b pend=%0b, expected mode=%0d cont=%0d cen=%0b pend=%0b",
                   $time, a.mode, a.cont, a.cen, a.pend, e.mode, e.cont, e.cen, e.pend);
        end
      end
    end
  end

  initial begin : stimulus
    bit m, u, d;
    rst_n = 1'b1;
    k_m = 0; k_u = 0; k_d = 0; frozen = 0; ph_val = '0;
    bus.key_mode = 0; bus.key_up = 0; bus.key_down = 0; bus.phase = '0;
    #2;
    reset_seq(0);

    // Full mode cycle, one step per press.
    repeat (5) begin cyc(1, 0, 0); run(69, 0, 0, 0); end

    // Short tap, then a 40-cycle hold.
    goto_cont();
    run(70, 0, 0, 0);
    run(3, 0, 1, 0);
    run(70, 0, 0, 0);
    run(40, 0, 1, 0);
    run(70, 0, 0, 0);

    // Saturation at both limits.
    run(400, 0, 1, 0);
    run(20, 0, 0, 0);
    run(500, 0, 0, 1);
    run(70, 0, 0, 0);

    // Both keys together, both keys during a hold, then up coincident with mode.
    run(10, 0, 1, 1);
    run(30, 0, 0, 0);
    run(20, 0, 1, 0);
    run(10, 0, 1, 1);
    run(10, 0, 0, 0);
    run(3, 1, 1, 0);
    run(70, 0, 0, 0);

    // Frozen phase: commits only via timeout.
    frozen = 1;
    cyc(1, 0, 0);
    run(150, 0, 0, 0);
    frozen = 0;

    // Reset mid-repeat, key still held through release.
    goto_cont();
    run(30, 0, 1, 0);
    reset_seq(1);
    run(5, 0, 1, 0);
    run(70, 0, 0, 0);

    // Randomised key activity.
    for (int blk = 0; blk < 6; blk++) begin
      goto_cont();
      for (int i = 0; i < 500; i++) begin
        m = ($urandom_range(0, 199) == 0);
        u = k_u ^ ($urandom_range(0, 11) == 0);
        d = k_d ^ ($urandom_range(0, 11) == 0);
        if ($urandom_range(0, 299) == 0) frozen = ~frozen;
        cyc(m, u, d);
      end
    end
    frozen = 0;
    run(80, 0, 0, 0);

    @(posedge clk);
    #6;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
